// File: rtl/qpsk_pkg.sv
// Shared QPSK types and constants: FSM state, dibit type, Gray-phase map and sine table helpers.
// Phases are expressed in eighths of a carrier cycle so any power-of-2 LUT depth can scale them.
package qpsk_pkg;

  typedef enum logic {IDLE, TX} state_e;

  typedef logic [1:0] dibit_t;

  localparam int PH_00 = 1;  // 45 deg
  localparam int PH_01 = 3;  // 135 deg
  localparam int PH_11 = 5;  // 225 deg
  localparam int PH_10 = 7;  // 315 deg

  localparam real PI = 3.14159265358979323846;

  function automatic int gray_phase(dibit_t d);
    int ph;
    case (d)
      2'b00:   ph = PH_00;
      2'b01:   ph = PH_01;
      2'b11:   ph = PH_11;
      default: ph = PH_10;
    endcase
    return ph;
  endfunction

  function automatic int midscale_code(int sw);
    return 1 << (sw - 1);
  endfunction

  // Rounds half away from zero so the table is symmetric about midscale.
  function automatic int sine_code(int k, int depth, int sw);
    real amp;
    real v;
    amp = real'((1 << (sw - 1)) - 1);
    v = amp * $sin(2.0 * PI * real'(k) / real'(depth));
    return midscale_code(sw) + ((v < 0.0) ? -$rtoi(0.5 - v) : $rtoi(v + 0.5));
  endfunction

endpackage

// File: rtl/qpsk_sine_lut.sv
// Combinational address-to-sample sine table, built at elaboration from LUT_DEPTH and SAMPLE_W.
// Zero latency; no flow control.
module qpsk_sine_lut
  import qpsk_pkg::*;
#(
  parameter int LUT_DEPTH = 32,
  parameter int SAMPLE_W  = 8,
  parameter int AW        = $clog2(LUT_DEPTH)
) (
  input  logic [AW-1:0]       addr,
  output logic [SAMPLE_W-1:0] sample
);

  logic [SAMPLE_W-1:0] rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
    localparam logic [SAMPLE_W-1:0] VAL = SAMPLE_W'(sine_code(k, LUT_DEPTH, SAMPLE_W));
    assign rom[k] = VAL;
  end

  assign sample = rom[addr];

endmodule

// File: rtl/qpsk_carrier_mod.sv
// QPSK modulator: serial bits -> Gray dibits -> phase-offset sine samples, one per tick, one clk latency.
// bit_ready drops while a dibit is pending; a pending (or just-completed) dibit starts gap-free at symbol end.
module qpsk_carrier_mod
  import qpsk_pkg::*;
#(
  parameter int LUT_DEPTH   = 32,
  parameter int CYC_PER_SYM = 2,
  parameter int SAMPLE_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic                bit_ready,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                sym_start,
  output logic                busy
);

  localparam int AW      = $clog2(LUT_DEPTH);
  localparam int SYM_LEN = LUT_DEPTH * CYC_PER_SYM;
  localparam int CW      = $clog2(SYM_LEN) + 1;
  localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(midscale_code(SAMPLE_W));

  state_e              state_q, state_d;
  logic                half_q, half_d;
  logic                msb_q, msb_d;
  logic                pend_full_q, pend_full_d;
  dibit_t              pend_q, pend_d;
  logic [AW-1:0]       off_q, off_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;

  logic                accept;
  logic                completes;
  dibit_t              in_dibit;
  logic [CW-1:0]       cnt_inc;
  logic                sym_end;
  logic                load;
  logic                go_idle;
  logic                advance;
  dibit_t              next_dibit;
  logic [AW-1:0]       next_off;
  logic [AW-1:0]       lut_addr;
  logic [SAMPLE_W-1:0] lut_sample;

  assign bit_ready = !pend_full_q && !rst;

  // Decode stage kept separate from next-state so the LUT address never depends on the LUT output.
  always_comb begin
    accept     = bit_valid && bit_ready;
    completes  = accept && half_q;
    in_dibit   = {msb_q, bit_in};
    cnt_inc    = cnt_q + CW'(1);
    sym_end    = (cnt_inc == CW'(SYM_LEN));
    load       = 1'b0;
    go_idle    = 1'b0;
    advance    = 1'b0;
    next_dibit = pend_q;
    if (tick) begin
      if (state_q == IDLE) begin
        load = pend_full_q;
      end else if (!sym_end) begin
        advance = 1'b1;
      end else if (pend_full_q) begin
        load = 1'b1;
      end else if (completes) begin
        load       = 1'b1;
        next_dibit = in_dibit;
      end else begin
        go_idle = 1'b1;
      end
    end
    next_off = AW'(gray_phase(next_dibit) * (LUT_DEPTH / 8));
    lut_addr = load ? next_off : (off_q + cnt_inc[AW-1:0]);
  end

  qpsk_sine_lut #(
    .LUT_DEPTH (LUT_DEPTH),
    .SAMPLE_W  (SAMPLE_W),
    .AW        (AW)
  ) u_lut (
    .addr   (lut_addr),
    .sample (lut_sample)
  );

  always_comb begin
    state_d     = state_q;
    half_d      = half_q;
    msb_d       = msb_q;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    start_d     = 1'b0;
    busy_d      = busy_q;

    if (accept) begin
      if (!half_q) begin
        msb_d  = bit_in;
        half_d = 1'b1;
      end else begin
        half_d      = 1'b0;
        pend_d      = in_dibit;
        pend_full_d = 1'b1;
      end
    end

    if (advance) begin
      cnt_d    = cnt_inc;
      sample_d = lut_sample;
      valid_d  = 1'b1;
    end

    // A bypassed dibit is consumed directly, so the buffer stays empty either way.
    if (load) begin
      pend_full_d = 1'b0;
      off_d       = next_off;
      cnt_d       = '0;
      sample_d    = lut_sample;
      valid_d     = 1'b1;
      start_d     = 1'b1;
      busy_d      = 1'b1;
      state_d     = TX;
    end

    if (go_idle) begin
      cnt_d    = '0;
      sample_d = MID;
      valid_d  = 1'b1;
      busy_d   = 1'b0;
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      half_q      <= 1'b0;
      msb_q       <= 1'b0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      off_q       <= '0;
      cnt_q       <= '0;
      sample_q    <= MID;
      valid_q     <= 1'b0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      half_q      <= half_d;
      msb_q       <= msb_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign sym_start    = start_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_qpsk_carrier_mod.sv
// Scoreboard bench for qpsk_carrier_mod: expected samples are queued per symbol and popped on sample_valid.
module tb_qpsk_carrier_mod;

  typedef struct packed {
    logic [7:0] s;
    logic       ss;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [7:0] sample_out;
  logic       sample_valid;
  logic       sym_start;
  logic       busy;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   obs_q[$];

  always #5 clk = ~clk;

  qpsk_carrier_mod dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sym_start    (sym_start),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_lut(int k);
    return 128 + int'(127.0 * $sin(6.283185307179586 * real'(k) / 32.0));
  endfunction

  function automatic int ref_off(logic [1:0] d);
    case (d)
      2'b00:   return 4;
      2'b01:   return 12;
      2'b11:   return 20;
      default: return 28;
    endcase
  endfunction

  task automatic push_symbol(input logic [1:0] d);
    int off;
    off = ref_off(d);
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back('{s: 8'(ref_lut((off + i) % 32)), ss: (i == 0)});
    end
  endtask

  task automatic push_idle();
    exp_q.push_back('{s: 8'd128, ss: 1'b0});
  endtask

  always @(negedge clk) begin
    if (sym_start && !sample_valid) check_eq("sym_start_without_valid", 1, 0);
    if (sample_valid) begin
      obs_q.push_back(int'(sample_out));
      if (exp_q.size() == 0) begin
        check_eq("unexpected_sample", 32'(sample_out), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sample", 32'(sample_out), 32'(e.s));
        check_eq("sym_start", 32'(sym_start), 32'(e.ss));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input int gap);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    if (gap > 0) step(gap);
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    bit_in = b;
    bit_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (bit_ready) break;
      n++;
      if (n > 2000) begin
        check_eq("bit_accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_sample"}, 32'(sample_out), 128);
    check_eq({tag, "_valid"}, 32'(sample_valid), 0);
    check_eq({tag, "_sym_start"}, 32'(sym_start), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_ready"}, 32'(bit_ready), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] run_d   [3];
    int         run_fst [3];
    int         run_5th [3];
    logic [7:0] stream_bits;

    rst = 1'b1; tick = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    check_eq("ready_in_reset", 32'(bit_ready), 0);
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    step(1);

    // Dibit 00, slow ticks.
    send_bit(1'b0);
    send_bit(1'b0);
    @(negedge clk);
    check_eq("pend_full_ready", 32'(bit_ready), 0);
    step(1);
    obs_q.delete();
    push_symbol(2'b00);
    push_idle();
    do_tick(49);
    @(negedge clk);
    check_eq("d00_busy", 32'(busy), 1);
    check_eq("d00_ready_after_load", 32'(bit_ready), 1);
    step(1);
    repeat (64) do_tick(49);
    @(negedge clk);
    check_eq("d00_busy_end", 32'(busy), 0);
    check_eq("d00_mid_end", 32'(sample_out), 128);
    check_eq("d00_count", obs_q.size(), 65);
    if (obs_q.size() > 4) begin
      check_eq("d00_first", obs_q[0], 218);
      check_eq("d00_fifth", obs_q[4], 255);
    end
    step(1);

    // Remaining phases, one isolated symbol each.
    run_d   = '{2'b01, 2'b11, 2'b10};
    run_fst = '{218, 38, 38};
    run_5th = '{128, 1, 128};
    for (int r = 0; r < 3; r++) begin
      send_bit(run_d[r][1]);
      send_bit(run_d[r][0]);
      obs_q.delete();
      push_symbol(run_d[r]);
      push_idle();
      repeat (65) do_tick(2);
      @(negedge clk);
      check_eq($sformatf("run%0d_count", r), obs_q.size(), 65);
      if (obs_q.size() > 4) begin
        check_eq($sformatf("run%0d_first", r), obs_q[0], run_fst[r]);
        check_eq($sformatf("run%0d_fifth", r), obs_q[4], run_5th[r]);
      end
      check_eq($sformatf("run%0d_busy", r), 32'(busy), 0);
      step(1);
    end

    // Four dibits streamed with bit_valid held high.
    stream_bits = 8'b00_01_11_10;
    obs_q.delete();
    push_symbol(2'b00);
    push_symbol(2'b01);
    push_symbol(2'b11);
    push_symbol(2'b10);
    push_idle();
    fork
      begin
        for (int i = 7; i >= 0; i--) begin
          int n;
          n = 0;
          bit_in = stream_bits[i];
          bit_valid = 1'b1;
          while (1) begin
            @(negedge clk);
            if (bit_ready) break;
            n++;
            if (n > 2000) begin
              check_eq("stream_accept_timeout", 0, 1);
              break;
            end
          end
          @(posedge clk);
          #1;
        end
        bit_valid = 1'b0;
      end
      begin
        step(6);
        for (int t = 1; t <= 257; t++) begin
          do_tick(2);
          if (t == 30) begin
            @(negedge clk);
            check_eq("stream_ready_low_pend", 32'(bit_ready), 0);
            step(1);
          end
        end
      end
    join
    @(negedge clk);
    check_eq("stream_count", obs_q.size(), 257);
    check_eq("stream_queue_empty", exp_q.size(), 0);
    check_eq("stream_busy_end", 32'(busy), 0);
    step(1);

    // Second bit of the next dibit lands on the symbol-ending tick.
    send_bit(1'b1);
    send_bit(1'b1);
    push_symbol(2'b11);
    push_symbol(2'b10);
    push_idle();
    do_tick(2);
    send_bit(1'b1);
    repeat (63) do_tick(2);
    bit_in = 1'b0;
    bit_valid = 1'b1;
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    bit_valid = 1'b0;
    @(negedge clk);
    check_eq("bypass_sym_start", 32'(sym_start), 1);
    check_eq("bypass_sample", 32'(sample_out), 38);
    check_eq("bypass_ready", 32'(bit_ready), 1);
    step(1);
    repeat (64) do_tick(2);
    @(negedge clk);
    check_eq("bypass_queue_empty", exp_q.size(), 0);
    check_eq("bypass_busy_end", 32'(busy), 0);
    step(1);

    // Reset mid-symbol with a half-collected bit.
    send_bit(1'b0);
    send_bit(1'b1);
    push_symbol(2'b01);
    do_tick(2);
    send_bit(1'b1);
    repeat (29) do_tick(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_vals("midrst");
    step(1);
    send_bit(1'b0);
    repeat (5) do_tick(2);
    @(negedge clk);
    check_eq("midrst_no_start_busy", 32'(busy), 0);
    check_eq("midrst_no_start_ready", 32'(bit_ready), 1);
    check_eq("midrst_no_start_sample", 32'(sample_out), 128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
